// File: rtl/uart_rx_word_loader.sv
// uart_rx_word_loader: drains bytes from the UART receive holding register,
// parses a length-prefixed boot stream (16-bit little-endian word count
// followed by little-endian 32-bit words) and writes the words sequentially
// into instruction memory starting at BASE_ADDR.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing 8-bit checksum
// byte (sum mod 256 of all data bytes) that must match for the load to pass.
//
// Receive handshake: rx_valid is the "byte available" flag. A byte is taken
// in the cycle rx_read_en=1 (rx_read_en = rx_valid & consuming state & no
// guard). rx_data/rx_ferr are captured in that same cycle, and the following
// cycle is a guard cycle in which rx_read_en is held 0 while the receiver
// drops its flag, so one byte is never popped twice.
module uart_rx_word_loader #(
    parameter int ADDR_W      = 10,
    parameter int BASE_ADDR   = 0,
    parameter int TIMEOUT_CYC = 5000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              rx_ferr,
    output logic              rx_read_en,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        err_code
);

    typedef enum logic [3:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_FINISH, S_CHK, S_DONE, S_ERR
    } state_t;

    localparam int                GAP_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [16:0]       MAX_LEN   = 17'(1 << ADDR_W);
    localparam logic [GAP_W-1:0]  GAP_LIMIT = GAP_W'(TIMEOUT_CYC - 1);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

    localparam logic [2:0] CODE_NONE = 3'b000;
    localparam logic [2:0] CODE_FERR = 3'b001;
    localparam logic [2:0] CODE_OVFL = 3'b010;
    localparam logic [2:0] CODE_TOUT = 3'b011;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] CODE_CSUM = 3'b100;
`endif

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        err_code_nxt;
    logic              guard;
    logic [15:0]       len;
    logic [ADDR_W:0]   index;
    logic [1:0]        byte_cnt;
    logic [23:0]       word;
    logic [GAP_W-1:0]  gap;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    logic              consuming;
    logic              accept;
    logic              start_ok;
    logic              timeout_hit;
    logic [16:0]       len_full;

    assign consuming   = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                         (state == S_DATA)   || (state == S_CHK);
    assign accept      = consuming && rx_valid && !guard;
    assign start_ok    = start && ((state == S_IDLE) || (state == S_ERR));
    // gap holds the number of cycles since the last pop (or since start), so
    // the error state becomes visible exactly TIMEOUT_CYC cycles after it.
    assign timeout_hit = consuming && !accept && (gap == GAP_LIMIT);
    assign len_full    = {1'b0, rx_data, len[7:0]};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic and the error code to latch on entry to ERR.
    always_comb begin
        state_nxt    = state;
        err_code_nxt = CODE_NONE;
        case (state)
            S_IDLE: if (start) state_nxt = S_LEN_LO;
            S_LEN_LO, S_LEN_HI, S_DATA, S_CHK: begin
                if (accept && rx_ferr) begin
                    state_nxt    = S_ERR;
                    err_code_nxt = CODE_FERR;
                end else if (accept) begin
                    case (state)
                        S_LEN_LO: state_nxt = S_LEN_HI;
                        S_LEN_HI: begin
                            if (len_full > MAX_LEN) begin
                                state_nxt    = S_ERR;
                                err_code_nxt = CODE_OVFL;
                            end else if (len_full == 17'd0) begin
                                state_nxt = S_FINISH;
                            end else begin
                                state_nxt = S_DATA;
                            end
                        end
                        S_DATA: if (byte_cnt == 2'd3) state_nxt = S_WRITE;
                        default: begin
`ifdef LOADER_CHECKSUM_EN
                            if (rx_data == csum) begin
                                state_nxt = S_DONE;
                            end else begin
                                state_nxt    = S_ERR;
                                err_code_nxt = CODE_CSUM;
                            end
`else
                            state_nxt = S_IDLE;
`endif
                        end
                    endcase
                end else if (timeout_hit) begin
                    state_nxt    = S_ERR;
                    err_code_nxt = CODE_TOUT;
                end
            end
            S_WRITE: begin
                if (17'(index) + 17'd1 == {1'b0, len}) state_nxt = S_FINISH;
                else                                   state_nxt = S_DATA;
            end
`ifdef LOADER_CHECKSUM_EN
            S_FINISH: state_nxt = S_CHK;
`else
            S_FINISH: state_nxt = S_DONE;
`endif
            S_DONE:   state_nxt = S_IDLE;
            S_ERR:    if (start) state_nxt = S_LEN_LO;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Status and strobe outputs decoded from the current state.
    always_comb begin
        rx_read_en = accept;
        imem_we    = (state == S_WRITE);
        busy       = consuming || (state == S_WRITE) || (state == S_FINISH);
        done       = (state == S_DONE);
        err        = (state == S_ERR);
    end

    // Datapath: byte capture, word assembly, counters and held write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            guard      <= 1'b0;
            len        <= '0;
            index      <= '0;
            byte_cnt   <= '0;
            word       <= '0;
            gap        <= '0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            err_code   <= CODE_NONE;
`ifdef LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            guard <= accept;
            if (start_ok) begin
                len      <= '0;
                index    <= '0;
                byte_cnt <= '0;
                gap      <= GAP_W'(1);
                err_code <= CODE_NONE;
`ifdef LOADER_CHECKSUM_EN
                csum     <= '0;
`endif
            end else begin
                if (state != S_ERR && state_nxt == S_ERR) err_code <= err_code_nxt;
                if (accept)         gap <= GAP_W'(1);
                else if (consuming) gap <= gap + GAP_W'(1);
                if (accept && !rx_ferr) begin
                    case (state)
                        S_LEN_LO: len[7:0]  <= rx_data;
                        S_LEN_HI: len[15:8] <= rx_data;
                        S_DATA: begin
                            case (byte_cnt)
                                2'd0: word[7:0]   <= rx_data;
                                2'd1: word[15:8]  <= rx_data;
                                2'd2: word[23:16] <= rx_data;
                                default: begin
                                    imem_addr  <= BASE + index[ADDR_W-1:0];
                                    imem_wdata <= {rx_data, word};
                                end
                            endcase
                            byte_cnt <= byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                            csum     <= csum + rx_data;
`endif
                        end
                        default: ;
                    endcase
                end
                if (state == S_WRITE) index <= index + (ADDR_W+1)'(1);
            end
        end
    end

endmodule
